// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan controller.
//   - Segment bit positions inside the {dp,g,f,e,d,c,b,a} byte.
//   - Active-high 7-bit glyphs ({g,f,e,d,c,b,a}) for hex digits 0..F and a blank pattern.
//   - hex_glyph(): nibble -> active-high glyph lookup.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] GLYPH_0   = 7'h3F;
  localparam logic [6:0] GLYPH_1   = 7'h06;
  localparam logic [6:0] GLYPH_2   = 7'h5B;
  localparam logic [6:0] GLYPH_3   = 7'h4F;
  localparam logic [6:0] GLYPH_4   = 7'h66;
  localparam logic [6:0] GLYPH_5   = 7'h6D;
  localparam logic [6:0] GLYPH_6   = 7'h7D;
  localparam logic [6:0] GLYPH_7   = 7'h07;
  localparam logic [6:0] GLYPH_8   = 7'h7F;
  localparam logic [6:0] GLYPH_9   = 7'h6F;
  localparam logic [6:0] GLYPH_A   = 7'h77;
  localparam logic [6:0] GLYPH_B   = 7'h7C;  // lower-case b
  localparam logic [6:0] GLYPH_C   = 7'h39;
  localparam logic [6:0] GLYPH_D   = 7'h5E;  // lower-case d
  localparam logic [6:0] GLYPH_E   = 7'h79;
  localparam logic [6:0] GLYPH_F   = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    unique case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational hex nibble to active-high segment pattern.
// Ports:
//   i_nibble  hex value 0..F
//   i_blank   1: force all segments off
//   o_seg     {g,f,e,d,c,b,a}, 1 = segment lit (polarity applied by the caller)
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = i_blank ? SEG_BLANK : hex_glyph(i_nibble);
  end

  assign o_seg = w_seg;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multi-digit 7-segment scan controller with double-buffered loading.
// A load writes a pending buffer; the displayed (shadow) buffer only changes at a frame
// boundary so a frame never mixes old and new digits.
// Optional build macro: SEG7_LEADING_BLANK_EN blanks digits above the highest nonzero nibble
// (digit 0 is never blanked, dp still honoured).
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   load        1-cycle strobe capturing data_in/dp_in
//   data_in     hex nibbles, nibble k -> digit k (k=0 rightmost)
//   dp_in       decimal point per digit
//   BCD7        registered {anodes, dp,g,f,e,d,c,b,a}, polarity per parameters
//   frame_done  high during the last cycle of the last digit's slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned CLK_DIV          = 1000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS+7:0]   BCD7,
  output logic                    frame_done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DigW = $clog2(NUM_DIGITS);
  // XOR masks: an inactive pin equals the mask, so reset and polarity share one constant.
  localparam logic [NUM_DIGITS-1:0] AnodeOff = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]            SegOff   = {8{SEG_ACTIVE_LOW}};

  logic [DivW-1:0]         r_div_cnt;
  logic [DigW-1:0]         r_digit;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [NUM_DIGITS+7:0]   r_bcd7;

  logic                    w_div_wrap;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_blank_mask;
  logic [NUM_DIGITS-1:0]   w_anodes;
  logic [3:0]              w_nibble;
  logic                    w_dp;
  logic                    w_blank;
  logic [6:0]              w_seg;
  logic [7:0]              w_seg_hi;

  assign w_div_wrap  = (r_div_cnt == DivW'(CLK_DIV - 1));
  assign w_frame_end = w_div_wrap && (r_digit == DigW'(NUM_DIGITS - 1));
  // Decoded from registered counters so a load in this same cycle lands on the boundary.
  assign frame_done  = w_frame_end;

`ifdef SEG7_LEADING_BLANK_EN
  always_comb begin
    logic w_seen_nz;
    w_seen_nz    = 1'b0;
    w_blank_mask = '0;
    // Walk from the most significant digit down; blank until a nonzero nibble appears.
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_seen_nz       = w_seen_nz | (r_shadow_data[4*k +: 4] != 4'h0);
      w_blank_mask[k] = ~w_seen_nz;
    end
  end
`else
  assign w_blank_mask = '0;
`endif

  always_comb begin
    w_anodes = '0;
    w_nibble = 4'h0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digit == DigW'(k)) begin
        w_anodes[k] = 1'b1;
        w_nibble    = r_shadow_data[4*k +: 4];
        w_dp        = r_shadow_dp[k];
        w_blank     = w_blank_mask[k];
      end
    end
  end

  seg7_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .o_seg    (w_seg)
  );

  always_comb begin
    w_seg_hi                = 8'h00;
    w_seg_hi[SEG_G:SEG_A]   = w_seg;
    w_seg_hi[SEG_DP]        = w_dp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_digit       <= '0;
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_bcd7        <= {AnodeOff, SegOff};
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DivW'(1);
      if (w_div_wrap) begin
        r_digit <= w_frame_end ? '0 : r_digit + DigW'(1);
      end
      if (w_frame_end) begin
        // A load on the boundary bypasses the pending buffer and wins over it.
        r_pend_valid <= 1'b0;
        if (load) begin
          r_shadow_data <= data_in;
          r_shadow_dp   <= dp_in;
        end else if (r_pend_valid) begin
          r_shadow_data <= r_pend_data;
          r_shadow_dp   <= r_pend_dp;
        end
      end else if (load) begin
        r_pend_data  <= data_in;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end
      r_bcd7 <= {w_anodes ^ AnodeOff, w_seg_hi ^ SegOff};
    end
  end

  assign BCD7 = r_bcd7;

endmodule
